axicb_skid_pipeline: RTL and testbench

AXICB_SKID_PIPELINE -- requirements
Module: axicb_skid_pipeline

---
 rtl/axicb_skid_pipeline_if.sv | 14 +
 rtl/axicb_skid_pipeline.sv | 125 ++++++++++++
 tb/tb_axicb_skid_pipeline.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_skid_pipeline_if.sv
// axicb_skid_pipeline_if: one valid/ready/data channel.
//   valid  - producer has a word on data
//   ready  - consumer can take the word this cycle
//   data   - payload, DATA_BUS_W bits
//   master - producer side, slave - consumer side
interface axicb_skid_pipeline_if #(
   parameter int DATA_BUS_W = 8
) ();
   logic                  valid;
   logic                  ready;
   logic [DATA_BUS_W-1:0] data;
   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axicb_skid_pipeline.sv
// axicb_skid_pipeline: chain of NB_PIPELINE valid/ready register slices.
//   aclk    - clock, rising edge
//   aresetn - asynchronous active-low reset
//   srst    - synchronous active-high reset
//   s_if    - upstream channel (i_valid/i_ready/i_data)
//   m_if    - downstream channel (o_valid/o_ready/o_data)
//   REG_MODE: 0 wires, 1 ready path registered, 2 ready and data paths registered
module axicb_skid_pipeline #(
   parameter int DATA_BUS_W  = 8,
   parameter int NB_PIPELINE = 1,
   parameter int REG_MODE    = 2
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    srst,
   axicb_skid_pipeline_if.slave    s_if,
   axicb_skid_pipeline_if.master   m_if
);
   if (NB_PIPELINE == 0 || REG_MODE == 0) begin : g_bypass
      assign m_if.valid = s_if.valid;
      assign m_if.data  = s_if.data;
      assign s_if.ready = m_if.ready;
   end else begin : g_pipe
      // index s is the input of stage s, index s+1 its output
      logic                  v [NB_PIPELINE+1];
      logic                  r [NB_PIPELINE+1];
      logic [DATA_BUS_W-1:0] d [NB_PIPELINE+1];
      assign v[0]           = s_if.valid;
      assign d[0]           = s_if.data;
      assign s_if.ready     = r[0];
      assign m_if.valid     = v[NB_PIPELINE];
      assign m_if.data      = d[NB_PIPELINE];
      assign r[NB_PIPELINE] = m_if.ready;
      for (genvar s = 0; s < NB_PIPELINE; s++) begin : g_stage
         if (REG_MODE == 1) begin : g_ready_only
            logic                  skid_valid_q, skid_valid_d;
            logic [DATA_BUS_W-1:0] skid_q, skid_d;
            logic                  i_ready_q;
            always_comb begin
               skid_valid_d = skid_valid_q;
               skid_d       = skid_q;
               if (srst) begin
                  skid_valid_d = 1'b0;
                  skid_d       = '0;
               end else if (skid_valid_q) begin
                  skid_valid_d = ~r[s+1];
               end else if (v[s] && i_ready_q && !r[s+1]) begin
                  skid_valid_d = 1'b1;
                  skid_d       = d[s];
               end
            end
            // i_ready tracks the next skid state so it is a pure flop output
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  skid_valid_q <= 1'b0;
                  skid_q       <= '0;
                  i_ready_q    <= 1'b0;
               end else begin
                  skid_valid_q <= skid_valid_d;
                  skid_q       <= skid_d;
                  i_ready_q    <= ~skid_valid_d;
               end
            end
            // pass-through is gated by i_ready so a word is never shown downstream
            // in the post-reset cycle where upstream cannot hand it over
            assign v[s+1] = skid_valid_q | (v[s] & i_ready_q);
            assign d[s+1] = skid_valid_q ? skid_q : (i_ready_q ? d[s] : '0);
            assign r[s]   = i_ready_q;
         end else begin : g_full
            typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
            state_t                state_q, state_d;
            logic [DATA_BUS_W-1:0] out_q, out_d, skid_q, skid_d;
            logic                  i_ready_q;
            logic                  in_fire;
            assign in_fire = v[s] & i_ready_q;
            always_comb begin
               state_d = state_q;
               out_d   = out_q;
               skid_d  = skid_q;
               if (srst) begin
                  state_d = EMPTY;
                  out_d   = '0;
                  skid_d  = '0;
               end else begin
                  case (state_q)
                     EMPTY: if (in_fire) begin
                        state_d = BUSY;
                        out_d   = d[s];
                     end
                     BUSY: if (in_fire && r[s+1]) begin
                        out_d   = d[s];
                     end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = d[s];
                     end else if (r[s+1]) begin
                        state_d = EMPTY;
                     end
                     FULL: if (r[s+1]) begin
                        state_d = BUSY;
                        out_d   = skid_q;
                     end
                     default: state_d = EMPTY;
                  endcase
               end
            end
            always_ff @(posedge aclk or negedge aresetn) begin
               if (!aresetn) begin
                  state_q   <= EMPTY;
                  out_q     <= '0;
                  skid_q    <= '0;
                  i_ready_q <= 1'b0;
               end else begin
                  state_q   <= state_d;
                  out_q     <= out_d;
                  skid_q    <= skid_d;
                  i_ready_q <= (state_d != FULL);
               end
            end
            assign v[s+1] = (state_q != EMPTY);
            assign d[s+1] = out_q;
            assign r[s]   = i_ready_q;
         end
      end
   end
endmodule

// File: tb/tb_axicb_skid_pipeline.sv
// tb_axicb_skid_pipeline: four instances (mode2 x1, mode1 x1, mode2 x3, bypass) against a queue model.
module tb_axicb_skid_pipeline;
   logic       clk = 1'b0;
   logic       aresetn;
   logic       srst;
   logic       iv [4];
   logic       ir [4];
   logic       ov [4];
   logic       ordy [4];
   logic [7:0] id [4];
   logic [7:0] od [4];
   int         vec = 0;
   int         errs = 0;
   int         cnt = 0;
   logic [7:0] q [4][$];
   bit         flag [4];
   logic [7:0] olog [4][$];
   int         ocyc [4][$];
   int         icyc [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   axicb_skid_pipeline_if #(.DATA_BUS_W(8)) si [4] ();
   axicb_skid_pipeline_if #(.DATA_BUS_W(8)) so [4] ();

   for (genvar g = 0; g < 4; g++) begin : g_ch
      assign si[g].valid = iv[g];
      assign si[g].data  = id[g];
      assign ir[g]       = si[g].ready;
      assign ov[g]       = so[g].valid;
      assign od[g]       = so[g].data;
      assign so[g].ready = ordy[g];
   end

   axicb_skid_pipeline #(.DATA_BUS_W(8), .NB_PIPELINE(1), .REG_MODE(2)) u_a (
      .aclk(clk), .aresetn(aresetn), .srst(srst), .s_if(si[0]), .m_if(so[0]));
   axicb_skid_pipeline #(.DATA_BUS_W(8), .NB_PIPELINE(1), .REG_MODE(1)) u_b (
      .aclk(clk), .aresetn(aresetn), .srst(srst), .s_if(si[1]), .m_if(so[1]));
   axicb_skid_pipeline #(.DATA_BUS_W(8), .NB_PIPELINE(3), .REG_MODE(2)) u_c (
      .aclk(clk), .aresetn(aresetn), .srst(srst), .s_if(si[2]), .m_if(so[2]));
   axicb_skid_pipeline #(.DATA_BUS_W(8), .NB_PIPELINE(1), .REG_MODE(0)) u_d (
      .aclk(clk), .aresetn(aresetn), .srst(srst), .s_if(si[3]), .m_if(so[3]));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr(input int k);
      olog[k].delete();
      ocyc[k].delete();
      icyc[k].delete();
   endtask

   // hold a word on channel k until it is accepted, bounded
   task automatic send(input int k, input logic [7:0] val);
      iv[k] = 1'b1;
      id[k] = val;
      for (int t = 0; t < 20; t++) begin
         if (ir[k]) begin
            cyc();
            iv[k] = 1'b0;
            return;
         end
         cyc();
      end
      chk("send_timeout", 0, 1);
      iv[k] = 1'b0;
   endtask

   // model: q holds words accepted but not yet delivered; the rules below are
   // stated in terms of that occupancy, not of any stage state
   always @(negedge clk) begin
      int         occ;
      logic [7:0] ex;
      for (int k = 0; k < 4; k++) begin
         if (!aresetn) begin
            q[k].delete();
            flag[k] = 1'b0;
         end
         if (k == 3) begin
            chk("byp_valid", ov[3], iv[3]);
            chk("byp_data", od[3], id[3]);
            chk("byp_ready", ir[3], ordy[3]);
         end else begin
            occ = q[k].size();
            if (k == 0) begin
               chk("a_ready", ir[0], flag[0] && occ < 2);
               chk("a_valid", ov[0], occ > 0);
            end else if (k == 1) begin
               chk("b_ready", ir[1], flag[1] && occ == 0);
               chk("b_valid", ov[1], occ > 0 || (iv[1] && flag[1]));
            end else begin
               if (!flag[2]) chk("c_ready_rst", ir[2], 0);
               chk("c_occ_le6", occ <= 6, 1);
               if (ov[2]) chk("c_nonempty", occ > 0, 1);
            end
            if (ov[k]) begin
               ex = occ > 0 ? q[k][0] : id[k];
               chk("model_data", od[k], ex);
            end
            if (!aresetn) chk("rst_data", od[k], 0);
            if (aresetn && !srst) begin
               if (iv[k] && ir[k]) begin
                  q[k].push_back(id[k]);
                  icyc[k].push_back(cnt);
               end
               if (ov[k] && ordy[k]) begin
                  olog[k].push_back(od[k]);
                  ocyc[k].push_back(cnt);
                  if (q[k].size() > 0) void'(q[k].pop_front());
               end
            end else begin
               q[k].delete();
            end
            flag[k] = aresetn;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int k = 0; k < 4; k++) begin
         iv[k] = 1'b0;
         id[k] = '0;
         ordy[k] = 1'b0;
      end
      aresetn = 1'b0;
      srst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_valid", ov[0], 0);
      chk("rst_a_data", od[0], 0);
      chk("rst_a_ready", ir[0], 0);
      chk("rst_b_ready", ir[1], 0);
      chk("rst_c_ready", ir[2], 0);
      chk("rst_c_valid", ov[2], 0);
      aresetn = 1'b1;
      cyc();
      chk("rel_a_ready", ir[0], 1);
      chk("rel_b_ready", ir[1], 1);
      chk("rel_c_ready", ir[2], 1);

      // streaming 0x01..0x10 through one mode-2 stage
      clr(0);
      ordy[0] = 1'b1;
      for (int i = 1; i <= 16; i++) send(0, 8'(i));
      repeat (4) cyc();
      chk("stream_cnt", olog[0].size(), 16);
      for (int i = 0; i < olog[0].size() && i < icyc[0].size() && i < 16; i++) begin
         chk("stream_data", olog[0][i], i + 1);
         chk("stream_lat", ocyc[0][i] - icyc[0][i], 1);
         if (i > 0) chk("stream_gap", ocyc[0][i] - ocyc[0][i-1], 1);
      end

      // backpressure: A1, A2 fill the stage, A3 waits upstream
      clr(0);
      ordy[0] = 1'b0;
      send(0, 8'hA1);
      send(0, 8'hA2);
      chk("bp_ready_low", ir[0], 0);
      chk("bp_hold_a1", od[0], 8'hA1);
      iv[0] = 1'b1;
      id[0] = 8'hA3;
      repeat (3) cyc();
      chk("bp_still_a1", od[0], 8'hA1);
      chk("bp_still_full", ir[0], 0);
      chk("bp_a3_held", icyc[0].size(), 2);
      ordy[0] = 1'b1;
      send(0, 8'hA3);
      repeat (4) cyc();
      chk("bp_cnt", olog[0].size(), 3);
      if (olog[0].size() == 3) begin
         chk("bp_o0", olog[0][0], 8'hA1);
         chk("bp_o1", olog[0][1], 8'hA2);
         chk("bp_o2", olog[0][2], 8'hA3);
      end

      // ready-only stage: 0x55 passes through, 0x66 lands in the skid
      clr(1);
      ordy[1] = 1'b1;
      iv[1] = 1'b1;
      id[1] = 8'h55;
      #1;
      chk("ro_pass_valid", ov[1], 1);
      chk("ro_pass_data", od[1], 8'h55);
      cyc();
      ordy[1] = 1'b0;
      id[1] = 8'h66;
      #1;
      chk("ro_ready_66", ir[1], 1);
      cyc();
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      #1;
      chk("ro_skid_ready", ir[1], 0);
      chk("ro_skid_valid", ov[1], 1);
      chk("ro_skid_data", od[1], 8'h66);
      cyc();
      chk("ro_ready_back", ir[1], 1);
      chk("ro_idle", ov[1], 0);
      chk("ro_cnt", olog[1].size(), 2);
      if (olog[1].size() == 2) begin
         chk("ro_o0", olog[1][0], 8'h55);
         chk("ro_o1", olog[1][1], 8'h66);
      end

      // three stages under stall hold exactly six words
      clr(2);
      ordy[2] = 1'b0;
      n = 0;
      for (int t = 0; t < 30; t++) begin
         iv[2] = 1'b1;
         id[2] = 8'hC0 + 8'(n);
         if (ir[2]) n++;
         cyc();
      end
      iv[2] = 1'b0;
      chk("ms_accepted", n, 6);
      chk("ms_ready_low", ir[2], 0);
      ordy[2] = 1'b1;
      repeat (10) cyc();
      chk("ms_cnt", olog[2].size(), 6);
      for (int i = 0; i < olog[2].size() && i < 6; i++) chk("ms_data", olog[2][i], 8'hC0 + i);
      clr(2);
      send(2, 8'h77);
      repeat (6) cyc();
      chk("ms_lat_cnt", olog[2].size(), 1);
      if (olog[2].size() == 1 && icyc[2].size() == 1) begin
         chk("ms_lat", ocyc[2][0] - icyc[2][0], 3);
         chk("ms_lat_data", olog[2][0], 8'h77);
      end

      // synchronous reset while full drops both held words
      clr(0);
      ordy[0] = 1'b0;
      send(0, 8'hB1);
      send(0, 8'hB2);
      chk("sr_full", ir[0], 0);
      srst = 1'b1;
      cyc();
      srst = 1'b0;
      chk("sr_valid", ov[0], 0);
      chk("sr_ready", ir[0], 1);
      chk("sr_data", od[0], 0);
      ordy[0] = 1'b1;
      repeat (4) cyc();
      chk("sr_dropped", olog[0].size(), 0);

      // asynchronous reset mid-operation
      clr(0);
      ordy[0] = 1'b0;
      send(0, 8'hD1);
      aresetn = 1'b0;
      #1;
      chk("ar_valid", ov[0], 0);
      chk("ar_data", od[0], 0);
      chk("ar_ready", ir[0], 0);
      cyc();
      aresetn = 1'b1;
      cyc();
      chk("ar_ready_back", ir[0], 1);
      ordy[0] = 1'b1;
      repeat (3) cyc();
      chk("ar_dropped", olog[0].size(), 0);

      // bypass instance follows its inputs every cycle
      for (int t = 0; t < 20; t++) begin
         iv[3] = 1'($urandom_range(0, 1));
         id[3] = 8'($urandom);
         ordy[3] = 1'($urandom_range(0, 1));
         #1;
         chk("byp_now_valid", ov[3], iv[3]);
         chk("byp_now_data", od[3], id[3]);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
